// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access sequencer.
//
// Contents:
//   dm_ctrl_e  - access-size/sign codes understood by data_memory
//   state_e    - sequencer states
//   dm_size()  - byte count of an access code, 0 for an unsupported code
package dmem_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    CAPTURE,
    ERROR
  } state_e;

  // A size of 0 doubles as the "illegal control code" flag, so callers
  // only need one lookup to both size and validate an access.
  function automatic logic [2:0] dm_size(input dm_ctrl_e ctrl);
    case (ctrl)
      DM_B, DM_BU: dm_size = 3'd1;
      DM_H, DM_HU: dm_size = 3'd2;
      DM_W:        dm_size = 3'd4;
      default:     dm_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, pointer returns to RR_INIT
//   req      in   [1:0] request lines (bit 0 = cpu, bit 1 = loader)
//   advance  in   pulsed by the owner when the current grant is accepted
//   grant    out  [1:0] one-hot grant, combinational from req and pointer
module rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_ptr;

  // A lone requester always wins; the pointer only settles ties.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // After a tie is resolved the pointer hands the next tie to the loser,
  // which is what keeps either side from being starved.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= RR_INIT;
    end else if (advance && (req == 2'b11)) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequencer/arbiter sharing the single data_memory port between the pipeline
// MEM stage (cpu_*) and the program/debug loader (ldr_*). Each granted access
// is validated, then driven onto the memory bus with a one-cycle dm_dmWr pulse
// for stores or a capture cycle for loads.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   cpu_req/we/addr/wdata/ctrl     MEM-stage request, held until cpu_ready
//   cpu_rdata/ready/err            one-cycle completion with load data / reject flag
//   ldr_*                          same as cpu_* for the loader
//   dm_address/dataWr/dmCtrl/dmWr  bus towards data_memory
//   dm_dataRd                      combinational read data from data_memory
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter bit          RR_INIT   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_ctrl,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  input  logic [2:0]  ldr_ctrl,
  output logic [31:0] ldr_rdata,
  output logic        ldr_ready,
  output logic        ldr_err,
  output logic [31:0] dm_address,
  output logic [31:0] dm_dataWr,
  output logic [2:0]  dm_dmCtrl,
  output logic        dm_dmWr,
  input  logic [31:0] dm_dataRd
);

  state_e      r_state;
  state_e      w_next;
  logic        r_side;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_ctrl;
  logic        r_dmWr;

  logic [1:0]  w_req;
  logic [1:0]  w_grant;
  logic        w_granted;
  logic        w_advance;
  logic        w_winSide;
  logic        w_winWe;
  logic [31:0] w_winAddr;
  logic [31:0] w_winWdata;
  logic [2:0]  w_winCtrl;
  logic [2:0]  w_size;
  logic [32:0] w_lastByte;
  logic        w_winBad;
  logic        w_busActive;
  logic        w_done;
  logic        w_err;
  logic [31:0] w_rdata;

  assign w_req = {ldr_req, cpu_req};

  rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_advance),
    .grant   (w_grant)
  );

  assign w_granted  = |w_grant;
  assign w_winSide  = w_grant[1];
  assign w_winWe    = w_winSide ? ldr_we    : cpu_we;
  assign w_winAddr  = w_winSide ? ldr_addr  : cpu_addr;
  assign w_winWdata = w_winSide ? ldr_wdata : cpu_wdata;
  assign w_winCtrl  = w_winSide ? ldr_ctrl  : cpu_ctrl;
  assign w_size     = dm_size(dm_ctrl_e'(w_winCtrl));

  // Validation of the winning request. The end address is formed in 33 bits
  // so an access near 0xFFFFFFFF cannot wrap around and look in range.
  always_comb begin
    w_lastByte = {1'b0, w_winAddr} + {30'd0, w_size} - 33'd1;
    w_winBad   = 1'b0;
    if (w_size == 3'd0) begin
      w_winBad = 1'b1;
    end else if ((w_size == 3'd2) && w_winAddr[0]) begin
      w_winBad = 1'b1;
    end else if ((w_size == 3'd4) && (w_winAddr[1:0] != 2'b00)) begin
      w_winBad = 1'b1;
    end else if (w_lastByte >= 33'(MEM_BYTES)) begin
      w_winBad = 1'b1;
    end
  end

  // Next-state logic. Arbitration only happens in IDLE, so a new request is
  // never accepted in the same cycle that a completion is signalled.
  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_granted) begin
          w_advance = 1'b1;
          w_next    = w_winBad ? ERROR : SETUP;
        end
      end
      SETUP:   w_next = r_we ? STROBE : CAPTURE;
      STROBE:  w_next = RELEASE;
      RELEASE: w_next = IDLE;
      CAPTURE: w_next = IDLE;
      ERROR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, payload latch and the write strobe. dm_dmWr comes straight from a
  // flop so memory sees a glitch-free edge, and reset clears it in the same
  // edge that returns the state to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dmWr  <= 1'b0;
      r_side  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_ctrl  <= 3'd0;
    end else begin
      r_state <= w_next;
      r_dmWr  <= (w_next == STROBE);
      if ((r_state == IDLE) && w_granted) begin
        r_side  <= w_winSide;
        r_we    <= w_winWe;
        r_addr  <= w_winAddr;
        r_wdata <= w_winWdata;
        r_ctrl  <= w_winCtrl;
      end
    end
  end

  // Bus and completion outputs decode from the registered state only;
  // a rejected access never reaches the bus.
  always_comb begin
    w_busActive = (r_state == SETUP) || (r_state == STROBE) ||
                  (r_state == RELEASE) || (r_state == CAPTURE);
    w_done      = (r_state == RELEASE) || (r_state == CAPTURE) ||
                  (r_state == ERROR);
    w_err       = (r_state == ERROR);
    w_rdata     = (r_state == CAPTURE) ? dm_dataRd : 32'd0;
  end

  assign dm_address = w_busActive ? r_addr  : 32'd0;
  assign dm_dataWr  = w_busActive ? r_wdata : 32'd0;
  assign dm_dmCtrl  = w_busActive ? r_ctrl  : 3'd0;
  assign dm_dmWr    = r_dmWr;

  assign cpu_ready = w_done & ~r_side;
  assign cpu_err   = w_err  & ~r_side;
  assign cpu_rdata = r_side ? 32'd0 : w_rdata;
  assign ldr_ready = w_done & r_side;
  assign ldr_err   = w_err  & r_side;
  assign ldr_rdata = r_side ? w_rdata : 32'd0;

endmodule
